// File: rtl/res_output_pkg.sv
// +--------------------------------------------------------------------+
// | res_output_pkg : shared constants and helpers for res_output_arb   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package res_output_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Channel-index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/res_fifo_ch.sv
// +--------------------------------------------------------------------+
// | res_fifo_ch : first-word-fall-through channel FIFO, sticky overflow|
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module res_fifo_ch #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_pop;
  logic             w_push;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign dout     = r_mem[r_rd_ptr];
  assign overflow = r_overflow;

  // A full FIFO still takes a write when its head is leaving this cycle.
  assign w_pop  = rd_en & ~empty;
  assign w_push = wr_en & (~full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (wr_en && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/res_output_arb.sv
// +--------------------------------------------------------------------+
// | res_output_arb : merges per-channel result FIFOs onto one stream   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module res_output_arb
  import res_output_pkg::*;
#(
  parameter  int NUM_PEGS    = 8,
  parameter  int DATA_TYPE   = 16,
  parameter  int PARA_BLOCKS = 4,
  parameter  int FIFO_DEPTH  = 16,
  parameter  int ARB_MODE    = 1,
  localparam int CH_W        = ch_w(PARA_BLOCKS + 1)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       ena,
  input  logic [PARA_BLOCKS:0]                       i_data_valid,
  input  logic [(PARA_BLOCKS+1)*NUM_PEGS*DATA_TYPE-1:0] i_data_bus,
  output logic [PARA_BLOCKS:0]                       o_in_ready,
  output logic [PARA_BLOCKS:0]                       o_overflow,
  input  logic                                       i_out_ready,
  output logic                                       o_data_valid,
  output logic [NUM_PEGS*DATA_TYPE-1:0]              o_data_bus,
  output logic [CH_W-1:0]                            o_data_chan
);

  localparam int NCH = PARA_BLOCKS + 1;
  localparam int W   = NUM_PEGS * DATA_TYPE;

  logic [W-1:0]    w_dout [NCH];
  logic [NCH-1:0]  w_full;
  logic [NCH-1:0]  w_empty;
  logic [NCH-1:0]  w_ovf;
  logic [NCH-1:0]  w_rd_en;
  logic            w_can_load;
  logic            w_grant_vld;
  logic [CH_W-1:0] w_grant_idx;
  logic            w_pop;
  int              w_idx;

  logic            r_valid;
  logic [W-1:0]    r_bus;
  logic [CH_W-1:0] r_chan;
  logic [CH_W-1:0] r_last;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    res_fifo_ch #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .din      (i_data_bus[i*W +: W]),
      .wr_en    (i_data_valid[i]),
      .rd_en    (w_rd_en[i]),
      .dout     (w_dout[i]),
      .full     (w_full[i]),
      .empty    (w_empty[i]),
      .overflow (w_ovf[i])
    );
    assign w_rd_en[i] = w_pop & (w_grant_idx == CH_W'(i));
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (!w_empty[i]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = CH_W'(i);
        end
      end
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        w_idx = (int'(r_last) + k) % NCH;
        if (!w_empty[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = CH_W'(w_idx);
        end
      end
    end
  end

  assign w_can_load = ena & (~r_valid | i_out_ready);
  assign w_pop      = w_can_load & w_grant_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
      r_chan  <= '0;
      r_last  <= CH_W'(PARA_BLOCKS);
    end else if (w_can_load) begin
      r_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_bus  <= w_dout[w_grant_idx];
        r_chan <= w_grant_idx;
        r_last <= w_grant_idx;
      end
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_in_ready   = ~w_full;
  assign o_overflow   = w_ovf;
  assign o_data_valid = r_valid;
  assign o_data_bus   = r_bus;
  assign o_data_chan  = r_chan;

endmodule

`default_nettype wire

// File: tb/tb_res_output_arb.sv
// +--------------------------------------------------------------------+
// | tb_res_output_arb : directed checks, round-robin and fixed modes   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_res_output_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         a_ena = 1'b0, a_ready = 1'b0;
  logic [4:0]   a_wv = '0;
  logic [639:0] a_bus = '0;
  logic [4:0]   a_in_ready, a_ovf;
  logic         a_valid;
  logic [127:0] a_dout;
  logic [2:0]   a_chan;

  logic         b_ena = 1'b0, b_ready = 1'b0;
  logic [4:0]   b_wv = '0;
  logic [639:0] b_bus = '0;
  logic [4:0]   b_in_ready, b_ovf;
  logic         b_valid;
  logic [127:0] b_dout;
  logic [2:0]   b_chan;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  res_output_arb #(.ARB_MODE(1)) u_a (
    .clk(clk), .rst(rst), .ena(a_ena), .i_data_valid(a_wv), .i_data_bus(a_bus),
    .o_in_ready(a_in_ready), .o_overflow(a_ovf), .i_out_ready(a_ready),
    .o_data_valid(a_valid), .o_data_bus(a_dout), .o_data_chan(a_chan));

  res_output_arb #(.ARB_MODE(0)) u_b (
    .clk(clk), .rst(rst), .ena(b_ena), .i_data_valid(b_wv), .i_data_bus(b_bus),
    .o_in_ready(b_in_ready), .o_overflow(b_ovf), .i_out_ready(b_ready),
    .o_data_valid(b_valid), .o_data_bus(b_dout), .o_data_chan(b_chan));

  function automatic logic [127:0] mk(input int c, input int w);
    logic [15:0] h;
    h = {c[7:0], w[7:0]};
    return {8{h}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", 128'(a_valid), 128'(0));
    chk("rst_bus", a_dout, 128'(0));
    chk("rst_chan", 128'(a_chan), 128'(0));
    chk("rst_ovf", 128'(a_ovf), 128'(0));
    chk("rst_in_ready", 128'(a_in_ready), 128'h1f);
    rst = 1'b0;

    // Single write on channel 2: two-edge latency, then valid drops
    a_ena = 1'b1; a_ready = 1'b1;
    a_wv = 5'b00100; a_bus[2*128 +: 128] = {8{16'hA5A5}};
    tick();
    a_wv = '0;
    chk("single_not_yet", 128'(a_valid), 128'(0));
    tick();
    chk("single_valid", 128'(a_valid), 128'(1));
    chk("single_chan", 128'(a_chan), 128'(2));
    chk("single_bus", a_dout, {8{16'hA5A5}});
    tick();
    chk("single_drop", 128'(a_valid), 128'(0));

    // Round-robin fairness: 5 channels x 3 words
    rst_pulse();
    a_ena = 1'b0;
    for (int w = 0; w < 3; w++) begin
      a_wv = 5'h1f;
      for (int c = 0; c < 5; c++) a_bus[c*128 +: 128] = mk(c, w);
      tick();
    end
    a_wv = '0;
    a_ena = 1'b1;
    tick();
    for (int j = 0; j < 15; j++) begin
      chk($sformatf("rr_valid%0d", j), 128'(a_valid), 128'(1));
      chk($sformatf("rr_chan%0d", j), 128'(a_chan), 128'(j % 5));
      chk($sformatf("rr_bus%0d", j), a_dout, mk(j % 5, j / 5));
      tick();
    end
    chk("rr_end", 128'(a_valid), 128'(0));

    // Fixed priority: channels 0 and 3 with 2 words each
    b_ena = 1'b0;
    for (int w = 0; w < 2; w++) begin
      b_wv = 5'b01001;
      b_bus[0 +: 128] = mk(0, w);
      b_bus[3*128 +: 128] = mk(3, w);
      tick();
    end
    b_wv = '0;
    b_ena = 1'b1; b_ready = 1'b1;
    tick();
    chk("fp_chan0", 128'(b_chan), 128'(0));
    chk("fp_bus0", b_dout, mk(0, 0));
    tick();
    chk("fp_chan1", 128'(b_chan), 128'(0));
    chk("fp_bus1", b_dout, mk(0, 1));
    tick();
    chk("fp_chan2", 128'(b_chan), 128'(3));
    chk("fp_bus2", b_dout, mk(3, 0));
    tick();
    chk("fp_chan3", 128'(b_chan), 128'(3));
    chk("fp_bus3", b_dout, mk(3, 1));
    tick();
    chk("fp_end", 128'(b_valid), 128'(0));

    // Backpressure on channel 3
    rst_pulse();
    a_ena = 1'b0;
    for (int w = 0; w < 3; w++) begin
      a_wv = 5'b01000; a_bus[3*128 +: 128] = mk(3, w);
      tick();
    end
    a_wv = '0;
    a_ena = 1'b1; a_ready = 1'b0;
    tick();
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", 128'(a_valid), 128'(1));
      chk("bp_chan", 128'(a_chan), 128'(3));
      chk("bp_bus", a_dout, mk(3, 0));
      chk("bp_count", 128'(u_a.g_ch[3].u_fifo.r_count), 128'(2));
      tick();
    end
    a_ready = 1'b1;
    tick();
    chk("bp_rel1", a_dout, mk(3, 1));
    tick();
    chk("bp_rel2", a_dout, mk(3, 2));
    chk("bp_rel2_valid", 128'(a_valid), 128'(1));
    tick();
    chk("bp_end", 128'(a_valid), 128'(0));

    // Full and overflow on channel 1
    rst_pulse();
    a_ena = 1'b0;
    for (int w = 0; w < 17; w++) begin
      a_wv = 5'b00010; a_bus[128 +: 128] = mk(1, w);
      tick();
      if (w == 14) chk("full_ready15", 128'(a_in_ready[1]), 128'(1));
      if (w == 15) begin
        chk("full_ready16", 128'(a_in_ready[1]), 128'(0));
        chk("full_ovf16", 128'(a_ovf[1]), 128'(0));
      end
    end
    a_wv = '0;
    chk("ovf_set", 128'(a_ovf), 128'b00010);
    a_ena = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("ovf_valid%0d", j), 128'(a_valid), 128'(1));
      chk($sformatf("ovf_bus%0d", j), a_dout, mk(1, j));
      tick();
    end
    chk("ovf_drained", 128'(a_valid), 128'(0));
    chk("ovf_sticky", 128'(a_ovf[1]), 128'(1));
    chk("ovf_ready_back", 128'(a_in_ready[1]), 128'(1));

    // Asynchronous reset mid-stream
    a_ena = 1'b0;
    for (int w = 0; w < 3; w++) begin
      a_wv = 5'b00001; a_bus[0 +: 128] = mk(0, w);
      tick();
    end
    a_wv = '0;
    a_ena = 1'b1;
    tick();
    chk("ar_pre_valid", 128'(a_valid), 128'(1));
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", 128'(a_valid), 128'(0));
    chk("ar_bus", a_dout, 128'(0));
    chk("ar_chan", 128'(a_chan), 128'(0));
    chk("ar_ovf", 128'(a_ovf), 128'(0));
    chk("ar_in_ready", 128'(a_in_ready), 128'h1f);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("ar_quiet", 128'(a_valid), 128'(0));
    a_wv = 5'b10000; a_bus[4*128 +: 128] = mk(4, 9);
    tick();
    a_wv = '0;
    tick();
    chk("ar_new_valid", 128'(a_valid), 128'(1));
    chk("ar_new_chan", 128'(a_chan), 128'(4));
    chk("ar_new_bus", a_dout, mk(4, 9));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
